dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter for the shared 1024-word data memory of the mips32 core. Port C is the core's load/store path and port D is a DMA/loader path used to preload or dump data memory. At most one access is issued to the single-port memory per cycle. A bounded burst lock lets the DMA port stream back-to-back accesses without starving the core.

## Interface
- AW, 10, word-address width (1024 words)
- DW, 32, data width
- MAX_BURST, 8, maximum consecutive locked DMA grants while C is requesting (range 1..15)

Ports:
- clk_x  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- c_req / d_req  in  1  access request; held until granted
- c_we / d_we  in  1  1 = write, 0 = read
- c_addr / d_addr  in  AW  word address
- c_wdata / d_wdata  in  DW  write data
- d_lock  in  1  DMA asks to keep the grant on its next request
- c_gnt / d_gnt  out  1  request accepted this cycle (combinational)
- c_rvalid / d_rvalid  out  1  read data valid (registered)
- c_rdata / d_rdata  out  DW  read data, valid only with rvalid
- mem_en, mem_we  out  1  memory strobe / write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, 1-cycle latency after mem_en & !mem_we

## Operation
- Registered state: `last` (0 = C, 1 = D), mode FSM {ARB, BURST}, 4-bit `burst_cnt`, and `rsel` / `rpend` (owner of the in-flight read).
- ARB mode, winner selection:
  - One requester: that requester wins.
  - Both requesting: the port not equal to `last` wins (round robin).
- BURST mode, winner selection:
  - D wins if d_req.
  - Otherwise C wins if c_req.
- Winner effects:
  - Winner's gnt = 1.
  - mem_en = 1; mem_we, mem_addr, mem_wdata are muxed from the winner.
  - `last` <= winner.
- No request: mem_en = 0 and mem_addr/mem_wdata = 0; `last` holds.
- FSM transitions:
  - ARB -> BURST: d_gnt & d_lock. Set burst_cnt = 1.
  - BURST, on each d_gnt with d_lock and c_req: burst_cnt++.
  - BURST, on d_gnt with d_lock and !c_req: burst_cnt holds. The cap only counts cycles in which C is actually waiting.
  - BURST -> ARB: !d_lock, or !d_req, or (c_req & burst_cnt == MAX_BURST).
    - When exiting on the cap, C is granted that same cycle.
    - After the cap exit, `last` = C, so D must re-arbitrate.
- Read return:
  - Any granted read sets rpend = 1 and rsel = winner.
  - Next cycle, the owner's rvalid = 1 and its rdata = mem_rdata. The non-owner's rdata = 0.
- Writes produce no response; gnt is the completion.
- Simultaneous read return and new grant is legal every cycle (fully pipelined, throughput 1 access/cycle).
- A requester that drops req before gnt is a protocol violation; behaviour is undefined.

## Timing
- Reset (async assert, sync-style deassert on the next clk_x edge) sets:
  - last = 1, so C wins the first contention.
  - mode = ARB, burst_cnt = 0, rpend = 0.
  - c_rvalid = d_rvalid = 0, c_rdata = d_rdata = 0.
  - gnt outputs follow their combinational equations.
- Reset mid-read: the pending rvalid is dropped and no response is issued.
- Grant latency: 0 cycles when uncontended; at most 1 cycle for C when contended in ARB; at most MAX_BURST cycles for C during a D burst.
- Read latency: rvalid exactly 1 cycle after gnt.
- burst_cnt saturates at MAX_BURST and never wraps.

## Configuration
- `DMEM_ARB_CPU_PRIO_EN` defined:
  - Round robin is replaced by fixed priority: C always wins contention in ARB mode.
  - D wins only when c_req = 0, or inside a BURST.
  - MAX_BURST capping is still enforced.
- Not defined: round robin as described above.

## Test plan
- Reset, then c_req read at addr 0x001, with the memory model holding 0x12153524 there:
  - c_gnt in cycle 0.
  - c_rvalid = 1 with c_rdata = 0x12153524 in cycle 1.
  - d_rvalid stays 0.
- Both ports request continuously (C read 0x002, D write 0x003 = 0xDEADBEEF):
  - Grants alternate C, D, C, D.
  - Memory word 0x003 equals 0xDEADBEEF after D's grant.
- D burst with d_lock = 1, 20 reads, c_req held, MAX_BURST = 8:
  - D is granted 8 consecutive cycles.
  - C is granted on cycle 8.
  - D resumes after one arbitration round.
- D burst with d_lock = 1 and c_req = 0 for 20 cycles:
  - 20 consecutive d_gnt.
  - burst_cnt stays at 1.
- rst_n pulsed low for 3 ns between a C read grant and its return edge:
  - No c_rvalid.
  - All outputs are at reset values.
  - The next C read completes normally.
- With `DMEM_ARB_CPU_PRIO_EN` defined, both requesting continuously without lock:
  - C is granted every cycle.
  - d_gnt = 0 until c_req drops, then D is granted in that same cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
// Signal bundle between the core port (C), the DMA/loader port (D) and the shared
// single-port data memory. The arbiter takes the slave view; requesters and memory take the master view.
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_lock;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    input  mem_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    output mem_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Core/DMA arbiter for the shared data memory: round robin with a bounded DMA burst lock.
// Define DMEM_ARB_CPU_PRIO_EN to give the core fixed priority outside bursts.
module dmem_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic           clk_x,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} mode_t;

  localparam logic [3:0] CAP = 4'(MAX_BURST);

  mode_t         mode;
  logic          last;
  logic [3:0]    burst_cnt;
  logic          rsel;
  logic          rpend;
  logic          rst_q;

  logic          c_win;
  logic          d_win;
  logic          cap_hit;
  logic          we_w;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] wdata_w;

  always_comb begin
    c_win   = 1'b0;
    d_win   = 1'b0;
    cap_hit = 1'b0;
    if (mode == BURST) begin
      // The cap only bites while C is waiting; C then takes this very cycle.
      cap_hit = bus.c_req && (burst_cnt == CAP);
      d_win   = bus.d_req && !cap_hit;
      c_win   = bus.c_req && !d_win;
    end else begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      c_win = bus.c_req;
`else
      c_win = bus.c_req && (!bus.d_req || last);
`endif
      d_win = bus.d_req && !c_win;
    end
  end

  always_comb begin
    we_w    = 1'b0;
    addr_w  = '0;
    wdata_w = '0;
    if (c_win) begin
      we_w    = bus.c_we;
      addr_w  = bus.c_addr;
      wdata_w = bus.c_wdata;
    end else if (d_win) begin
      we_w    = bus.d_we;
      addr_w  = bus.d_addr;
      wdata_w = bus.d_wdata;
    end
  end

  assign bus.c_gnt     = c_win;
  assign bus.d_gnt     = d_win;
  assign bus.mem_en    = c_win || d_win;
  assign bus.mem_we    = we_w;
  assign bus.mem_addr  = addr_w;
  assign bus.mem_wdata = wdata_w;

  // Read return: memory data lands one cycle after the grant, steered to the owner.
  assign bus.c_rvalid = rpend && !rsel;
  assign bus.d_rvalid = rpend && rsel;
  assign bus.c_rdata  = (rpend && !rsel) ? bus.mem_rdata : '0;
  assign bus.d_rdata  = (rpend && rsel)  ? bus.mem_rdata : '0;

  // Reset asserts asynchronously but releases only after the next clock edge.
  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= ARB;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
      rsel      <= 1'b0;
      rpend     <= 1'b0;
    end else if (!rst_q) begin
      mode      <= ARB;
      last      <= 1'b1;
      burst_cnt <= 4'd0;
      rsel      <= 1'b0;
      rpend     <= 1'b0;
    end else begin
      rpend <= (c_win || d_win) && !we_w;
      if (c_win || d_win) begin
        rsel <= d_win;
        last <= d_win;
      end
      case (mode)
        ARB: begin
          if (d_win && bus.d_lock) begin
            mode      <= BURST;
            burst_cnt <= 4'd1;
          end
        end
        BURST: begin
          if (!bus.d_lock || !bus.d_req || cap_hit) begin
            mode      <= ARB;
            burst_cnt <= 4'd0;
          end else if (bus.c_req && burst_cnt != CAP) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for dmem_arbiter with a 1024-word behavioural memory behind it.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk_x   = 1'b0;
  logic rst_n   = 1'b0;
  logic mem_rst = 1'b1;
  int   n_vec   = 0;
  int   n_bad   = 0;
  logic exp_c;

  logic [DW-1:0] mem [1024];
  logic [1023:0] wr_ok;

  always #5 clk_x = ~clk_x;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8)) dut (
    .clk_x (clk_x),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Unwritten words read back as a fixed pattern; word 1 holds the known constant.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 10'd1) ? 32'h1215_3524 : (32'hA500_0000 | {22'd0, a});
  endfunction

  always @(posedge clk_x) begin
    if (mem_rst) begin
      wr_ok <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]   <= bus.mem_wdata;
        wr_ok[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= wr_ok[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic c_drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd;
  endtask

  task automatic d_drive(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic lock);
    bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_lock = lock;
  endtask

  task automatic idle();
    c_drive(1'b0, 1'b0, '0, '0);
    d_drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    idle();
    repeat (2) @(negedge clk_x);
    #1;
    chk("rst_c_rvalid", bus.c_rvalid, 1'b0);
    chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
    chk("rst_c_rdata", bus.c_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_c_gnt", bus.c_gnt, 1'b0);
    chk("rst_d_gnt", bus.d_gnt, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 10'h000);
    chk("rst_last", dut.last, 1'b1);
    chk("rst_burst_cnt", dut.burst_cnt, 4'd0);

    @(negedge clk_x); rst_n = 1'b1; mem_rst = 1'b0;

    // Single uncontended C read of word 1
    @(negedge clk_x); c_drive(1'b1, 1'b0, 10'h001, '0); #1;
    chk("t1_c_gnt", bus.c_gnt, 1'b1);
    chk("t1_d_gnt", bus.d_gnt, 1'b0);
    chk("t1_mem_addr", bus.mem_addr, 10'h001);
    chk("t1_mem_we", bus.mem_we, 1'b0);
    @(negedge clk_x); idle(); #1;
    chk("t1_c_rvalid", bus.c_rvalid, 1'b1);
    chk("t1_c_rdata", bus.c_rdata, 32'h1215_3524);
    chk("t1_d_rvalid", bus.d_rvalid, 1'b0);

    // Single D read of word 3 (leaves last = D)
    @(negedge clk_x); d_drive(1'b1, 1'b0, 10'h003, '0, 1'b0); #1;
    chk("t1d_d_gnt", bus.d_gnt, 1'b1);
    chk("t1d_c_gnt", bus.c_gnt, 1'b0);
    @(negedge clk_x); idle(); #1;
    chk("t1d_d_rvalid", bus.d_rvalid, 1'b1);
    chk("t1d_d_rdata", bus.d_rdata, 32'hA500_0003);
    chk("t1d_c_rdata", bus.c_rdata, 32'h0);

    // Continuous contention: C reads 0x002, D writes 0xDEADBEEF to 0x003
    @(negedge clk_x);
    c_drive(1'b1, 1'b0, 10'h002, '0);
    d_drive(1'b1, 1'b1, 10'h003, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk_x);
      #1;
`ifdef DMEM_ARB_CPU_PRIO_EN
      chk("t2_c_gnt", bus.c_gnt, 1'b1);
      chk("t2_d_gnt", bus.d_gnt, 1'b0);
`else
      chk("t2_c_gnt", bus.c_gnt, (i % 2) == 0);
      chk("t2_d_gnt", bus.d_gnt, (i % 2) == 1);
      if (i == 1) chk("t2_c_rdata", bus.c_rdata, 32'hA500_0002);
`endif
    end
    @(negedge clk_x); c_drive(1'b0, 1'b0, '0, '0); #1;
    chk("t2_d_gnt_on_c_drop", bus.d_gnt, 1'b1);
    @(negedge clk_x); idle();
    @(negedge clk_x); c_drive(1'b1, 1'b0, 10'h003, '0); #1;
    chk("t2_rd3_c_gnt", bus.c_gnt, 1'b1);
    @(negedge clk_x); idle(); #1;
    chk("t2_rd3_c_rvalid", bus.c_rvalid, 1'b1);
    chk("t2_rd3_c_rdata", bus.c_rdata, 32'hDEAD_BEEF);

    // Locked D burst, C waiting from the second cycle on
    @(negedge clk_x); d_drive(1'b1, 1'b0, 10'h010, '0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk_x);
      if (i == 1) c_drive(1'b1, 1'b0, 10'h005, '0);
      #1;
`ifdef DMEM_ARB_CPU_PRIO_EN
      exp_c = (i >= 8);
`else
      exp_c = (i == 8) || (i == 17);
`endif
      chk("t3_c_gnt", bus.c_gnt, exp_c);
      chk("t3_d_gnt", bus.d_gnt, !exp_c);
      if (i == 1) chk("t3_d_rdata", bus.d_rdata, 32'hA500_0010);
      if (i == 8) chk("t3_cnt_cap", dut.burst_cnt, 4'd8);
      if (i == 9) chk("t3_c_rdata", bus.c_rdata, 32'hA500_0005);
    end
    @(negedge clk_x); idle();

    // Locked D write burst with C idle: counter must not advance past 1
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_x);
      d_drive(1'b1, 1'b1, 10'(32 + i), 32'h5000_0000 + i, 1'b1); #1;
      chk("t4_d_gnt", bus.d_gnt, 1'b1);
      if (i == 7) chk("t4_mem_addr", bus.mem_addr, 10'h027);
    end
    chk("t4_burst_cnt", dut.burst_cnt, 4'd1);
    @(negedge clk_x); idle();
    @(negedge clk_x); c_drive(1'b1, 1'b0, 10'h02A, '0); #1;
    chk("t4_rd_c_gnt", bus.c_gnt, 1'b1);
    @(negedge clk_x); idle(); #1;
    chk("t4_rd_c_rdata", bus.c_rdata, 32'h5000_000A);

    // Reset pulse between a C read grant and its return edge
    @(negedge clk_x); c_drive(1'b1, 1'b0, 10'h001, '0); #1;
    chk("t5_c_gnt", bus.c_gnt, 1'b1);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk_x); idle(); #1;
    chk("t5_c_rvalid", bus.c_rvalid, 1'b0);
    chk("t5_d_rvalid", bus.d_rvalid, 1'b0);
    chk("t5_c_rdata", bus.c_rdata, 32'h0);
    chk("t5_mem_en", bus.mem_en, 1'b0);
    chk("t5_mem_wdata", bus.mem_wdata, 32'h0);
    chk("t5_last", dut.last, 1'b1);
    chk("t5_burst_cnt", dut.burst_cnt, 4'd0);
    @(negedge clk_x);
    c_drive(1'b1, 1'b0, 10'h002, '0);
    d_drive(1'b1, 1'b0, 10'h003, '0, 1'b0); #1;
    chk("t5_first_c_gnt", bus.c_gnt, 1'b1);
    chk("t5_first_d_gnt", bus.d_gnt, 1'b0);
    @(negedge clk_x); c_drive(1'b0, 1'b0, '0, '0); #1;
    chk("t5_d_gnt", bus.d_gnt, 1'b1);
    chk("t5_c_rvalid2", bus.c_rvalid, 1'b1);
    chk("t5_c_rdata2", bus.c_rdata, 32'hA500_0002);
    @(negedge clk_x); idle(); #1;
    chk("t5_d_rvalid", bus.d_rvalid, 1'b1);
    chk("t5_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    chk("t5_c_rvalid3", bus.c_rvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
